huffman_frame_ctrl: RTL and testbench
=====================================

// Module: huffman_frame_ctrl
// PURPOSE
//  Frame sequencer for the 6-symbol huffman core. It clears the core and streams one frame of
//  gray pixels into it. It then waits for the core's CNT_valid and code_valid pulses and raises
//  done. Sits between the host pixel stream and the core. Adds a watchdog so the host is never hung.
// PARAMETERS
//  FRAME_LEN  100  pixels per frame (1..255)
//  TIMEOUT    255  max cycles in each WAIT_* state before err_timeout (1..255)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  start        in   1  1-cycle pulse: begin a frame (ignored unless IDLE)
//  pix_valid    in   1  host pixel valid
//  pix_data     in   8  host pixel, legal symbols 1..6
//  pix_ready    out  1  pixel accepted when pix_valid & pix_ready
//  core_rst     out  1  drives the core reset input
//  gray_valid   out  1  to core
//  gray_data    out  8  to core
//  cnt_valid_i  in   1  core CNT_valid pulse
//  code_valid_i in   1  core code_valid level
//  busy         out  1  high in every state except IDLE
//  done         out  1  1-cycle pulse: core codes valid for this frame
//  err_timeout  out  1  sticky until next start; watchdog expired
//  err_range    out  1  sticky until next start; an illegal pixel was seen
//  frame_cnt    out  8  completed-frame counter; wraps 255->0
// BEHAVIOUR
//  Reset values: core_rst=1; all other outputs 0; state=IDLE; counters 0.
//  All outputs are registered.
//  FSM: IDLE -start-> CLR -> FEED -(FRAME_LEN accepted)-> WAIT_CNT -cnt_valid_i-> WAIT_CODE
//       -code_valid_i-> DONE -> IDLE. Either WAIT_* state goes to IDLE via watchdog.
//  IDLE: core_rst=0 and pix_ready=0. A start pulse clears err_* and moves to CLR.
//  CLR: core_rst=1 for exactly 1 cycle, then FEED. This zeroes the core counters.
//  FEED:
//   - pix_ready=1.
//   - Each handshake registers gray_valid=1 and gray_data for the next cycle.
//   - A cycle with no handshake drives gray_valid=0.
//   - pix_cnt increments on each handshake. When it reaches FRAME_LEN, leave FEED and drop pix_ready the next cycle.
//   - The core treats any gray_valid=0 cycle as end of frame. FEED must therefore present a
//     contiguous burst: after the first handshake, a gap before FRAME_LEN sets err_range.
//   - Gaps before the first handshake are allowed.
//   - pix_data of 0 or >6 sets err_range and is forwarded as 6, matching the core default bucket.
//  WAIT_CNT / WAIT_CODE:
//   - An 8-bit watchdog resets on entry and increments each cycle.
//   - When it reaches TIMEOUT: err_timeout=1, core_rst=1 for 1 cycle, go to IDLE.
//   - A frame with zero symbol-1 pixels never raises cnt_valid_i and must end by timeout.
//   - The event pulse and watchdog expiry may arrive in the same cycle. The event wins.
//  DONE: done=1 for 1 cycle; frame_cnt+1 (wraps 255->0); then IDLE. core_rst stays 0 so core outputs hold.
//  start outside IDLE is ignored. A cnt_valid_i arriving during FEED is ignored; it is a core bug.
//  Async reset mid-frame aborts everything. It asserts core_rst immediately.
//  No partial-frame state survives the reset.
// STRUCTURE
//  Shared package huffman_pkg:
//   - state enum {IDLE, CLR, FEED, WAIT_CNT, WAIT_CODE, DONE}
//   - SYM_MIN=1, SYM_MAX=6, SYM_DEFAULT=6
//   - width constants CNT_W=8, PIX_W=8
//  Sub-module hfc_watchdog: 8-bit counter with clear/enable/expire.
//  FSM and datapath registers stay in this module.
// TESTING
//  1 FRAME_LEN=6, burst 1,2,3,4,5,6 with a model core -> gray_valid high exactly 6 cycles,
//    done one cycle after code_valid_i, frame_cnt=1.
//  2 pixel 0 then 9 inside frame -> gray_data=6 both times, err_range=1, frame completes.
//  3 frame of all 6s (no symbol 1) -> no cnt_valid_i; after TIMEOUT=255 cycles:
//    err_timeout=1, core_rst 1-cycle pulse, state IDLE, done never pulses.
//  4 pix_valid gap after 3rd handshake -> err_range=1, pix_ready held until 6 accepted.
//  5 assert reset mid-FEED -> core_rst=1, busy=0, pix_ready=0 same cycle.
//    Next start runs a clean frame with frame_cnt unchanged at 0.
//  6 start pulses while busy, and cnt_valid_i & expiry in the same cycle ->
//    extra starts ignored; WAIT_CODE entered, no err_timeout.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared types and constants for the huffman frame controller.
// The symbol helper keeps the legal pixel range in one place.
package huffman_pkg;

  localparam int CNT_W = 8;
  localparam int PIX_W = 8;

  localparam logic [PIX_W-1:0] SYM_MIN     = 8'd1;
  localparam logic [PIX_W-1:0] SYM_MAX     = 8'd6;
  localparam logic [PIX_W-1:0] SYM_DEFAULT = 8'd6;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    WAIT_CNT,
    WAIT_CODE,
    DONE
  } state_t;

  function automatic logic sym_legal(input logic [PIX_W-1:0] pix);
    return (pix >= SYM_MIN) && (pix <= SYM_MAX);
  endfunction

endpackage

// File: rtl/huffman_frame_ctrl_if.sv
// Host/core-facing signal bundle of the frame controller.
// master = host and core side, slave = the controller itself.
interface huffman_frame_ctrl_if;
  import huffman_pkg::*;

  logic             start;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_ready;
  logic             core_rst;
  logic             gray_valid;
  logic [PIX_W-1:0] gray_data;
  logic             cnt_valid_i;
  logic             code_valid_i;
  logic             busy;
  logic             done;
  logic             err_timeout;
  logic             err_range;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output start, pix_valid, pix_data, cnt_valid_i, code_valid_i,
    input  pix_ready, core_rst, gray_valid, gray_data, busy, done,
           err_timeout, err_range, frame_cnt
  );

  modport slave (
    input  start, pix_valid, pix_data, cnt_valid_i, code_valid_i,
    output pix_ready, core_rst, gray_valid, gray_data, busy, done,
           err_timeout, err_range, frame_cnt
  );
endinterface

// File: rtl/huffman_frame_ctrl_watchdog.sv
// Wait-state watchdog: counts cycles spent in a WAIT_* state.
// o_expire marks the LIMIT-th cycle, so a wait state lasts at most LIMIT cycles.
module hfc_watchdog
  import huffman_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = i_en && (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/huffman_frame_ctrl.sv
// Frame sequencer: clears the huffman core, streams one frame of pixels,
// then waits for the core's count/code events under a watchdog.
module huffman_frame_ctrl
  import huffman_pkg::*;
#(
  parameter int FRAME_LEN = 100,
  parameter int TIMEOUT   = 255
) (
  input logic clk,
  input logic reset,
  huffman_frame_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_pix_cnt, w_pix_cnt_next;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_next;
  logic             r_err_range, w_err_range_next;
  logic             r_err_timeout, w_err_timeout_next;
  logic             r_pix_ready, r_core_rst, r_gray_valid, r_busy, r_done;
  logic [PIX_W-1:0] r_gray_data;

  logic             w_handshake, w_legal, w_timeout;
  logic             w_wd_clr, w_wd_en, w_wd_expire;
  logic [PIX_W-1:0] w_pix_clean;

  assign w_handshake = (r_state == FEED) && bus.pix_valid && r_pix_ready;
  assign w_legal     = sym_legal(bus.pix_data);
  // Illegal symbols go to the core's default bucket rather than being dropped.
  assign w_pix_clean = w_legal ? bus.pix_data : SYM_DEFAULT;

  assign w_wd_en  = (r_state == WAIT_CNT) || (r_state == WAIT_CODE);
  assign w_wd_clr = (w_state_next != r_state);

  hfc_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_wd_expire)
  );

  always_comb begin
    w_state_next       = r_state;
    w_pix_cnt_next     = r_pix_cnt;
    w_frame_cnt_next   = r_frame_cnt;
    w_err_range_next   = r_err_range;
    w_err_timeout_next = r_err_timeout;
    w_timeout          = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next       = CLR;
          w_err_range_next   = 1'b0;
          w_err_timeout_next = 1'b0;
        end
      end
      CLR: begin
        w_state_next   = FEED;
        w_pix_cnt_next = '0;
      end
      FEED: begin
        if (w_handshake) begin
          w_pix_cnt_next = r_pix_cnt + 1'b1;
          if (!w_legal) w_err_range_next = 1'b1;
          if (r_pix_cnt == FRAME_LAST) w_state_next = WAIT_CNT;
        end else if (r_pix_cnt != '0) begin
          // The core reads any idle cycle as end of frame, so a mid-burst gap corrupts it.
          w_err_range_next = 1'b1;
        end
      end
      WAIT_CNT: begin
        if (bus.cnt_valid_i) w_state_next = WAIT_CODE;
        else if (w_wd_expire) w_timeout = 1'b1;
      end
      WAIT_CODE: begin
        if (bus.code_valid_i) begin
          w_state_next     = DONE;
          w_frame_cnt_next = r_frame_cnt + 1'b1;
        end else if (w_wd_expire) begin
          w_timeout = 1'b1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_timeout) begin
      w_state_next       = IDLE;
      w_err_timeout_next = 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pix_cnt     <= '0;
      r_frame_cnt   <= '0;
      r_err_range   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_pix_ready   <= 1'b0;
      r_core_rst    <= 1'b1;
      r_gray_valid  <= 1'b0;
      r_gray_data   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pix_cnt     <= w_pix_cnt_next;
      r_frame_cnt   <= w_frame_cnt_next;
      r_err_range   <= w_err_range_next;
      r_err_timeout <= w_err_timeout_next;
      r_pix_ready   <= (w_state_next == FEED);
      r_core_rst    <= (w_state_next == CLR) || w_timeout;
      r_gray_valid  <= w_handshake;
      r_gray_data   <= w_handshake ? w_pix_clean : '0;
      r_busy        <= (w_state_next != IDLE);
      r_done        <= (w_state_next == DONE);
    end
  end

  assign bus.pix_ready   = r_pix_ready;
  assign bus.core_rst    = r_core_rst;
  assign bus.gray_valid  = r_gray_valid;
  assign bus.gray_data   = r_gray_data;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_range   = r_err_range;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_huffman_frame_ctrl.sv
// Bench for huffman_frame_ctrl: table of frames plus hand-written corner sequences,
// with a gray-pixel scoreboard and a simple behavioural core response.
module tb_huffman_frame_ctrl;

  localparam int FLEN = 6;
  localparam int TMO  = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  huffman_frame_ctrl_if bus ();

  huffman_frame_ctrl #(.FRAME_LEN(FLEN), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [47:0] px;
    int          gap_after;
    int          start_at;
    bit          exp_err;
  } frame_t;

  frame_t      frames[5];
  int          n_vec = 0;
  int          n_err = 0;
  int          gv_count = 0;
  int          done_count = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_fc = 8'd0;

  function automatic logic [47:0] mk(input logic [7:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  function automatic logic [7:0] model_sym(input logic [7:0] p);
    if (p == 8'd0 || p > 8'd6) return 8'd6;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every gray pixel the DUT emits is matched against the queue.
  always @(negedge clk) begin
    if (bus.gray_valid) begin
      gv_count++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL gray_unexpected: got gray_data 0x%0h, expected no pixel", bus.gray_data);
      end else begin
        check("gray_data", bus.gray_data, exp_q.pop_front());
      end
    end
    if (bus.done) done_count++;
  end

  task automatic begin_frame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("clr_core_rst", bus.core_rst, 1);
    check("clr_busy", bus.busy, 1);
    check("clr_pix_ready", bus.pix_ready, 0);
    check("clr_err_range", bus.err_range, 0);
    check("clr_err_timeout", bus.err_timeout, 0);
    tick();
    check("feed_core_rst", bus.core_rst, 0);
    check("feed_pix_ready", bus.pix_ready, 1);
    gv_count = 0;
  endtask

  task automatic feed(input logic [47:0] px, input int gap_after, input int start_at);
    int k = 0;
    bit gapped = 0;
    while (k < FLEN) begin
      check($sformatf("pix_ready[%0d]", k), bus.pix_ready, 1);
      bus.start = (k == start_at);
      if (k == gap_after && !gapped) begin
        bus.pix_valid = 1'b0;
        gapped = 1;
      end else begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = px[8*k +: 8];
        exp_q.push_back(model_sym(px[8*k +: 8]));
        k++;
      end
      tick();
    end
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'd0;
    bus.start     = 1'b0;
    check("pix_ready_drop", bus.pix_ready, 0);
  endtask

  task automatic run_frame(input frame_t f);
    bit has_one = 0;
    int d0;
    for (int k = 0; k < FLEN; k++)
      if (model_sym(f.px[8*k +: 8]) == 8'd1) has_one = 1;
    d0 = done_count;
    begin_frame();
    feed(f.px, f.gap_after, f.start_at);
    tick();
    check("gray_cycles", gv_count, FLEN);
    check("err_range", bus.err_range, f.exp_err);
    if (has_one) begin
      bus.cnt_valid_i = 1'b1;
      tick();
      bus.cnt_valid_i = 1'b0;
      check("wait_code_busy", bus.busy, 1);
      bus.code_valid_i = 1'b1;
      tick();
      bus.code_valid_i = 1'b0;
      exp_fc++;
      check("done", bus.done, 1);
      check("frame_cnt", bus.frame_cnt, exp_fc);
      tick();
      check("done_pulse_end", bus.done, 0);
      check("idle_busy", bus.busy, 0);
    end else begin
      repeat (TMO - 2) @(posedge clk);
      #1;
      check("pre_expiry_timeout", bus.err_timeout, 0);
      check("pre_expiry_busy", bus.busy, 1);
      tick();
      check("expiry_timeout", bus.err_timeout, 1);
      check("expiry_core_rst", bus.core_rst, 1);
      check("expiry_busy", bus.busy, 0);
      check("expiry_frame_cnt", bus.frame_cnt, exp_fc);
      tick();
      check("post_expiry_core_rst", bus.core_rst, 0);
      check("timeout_sticky", bus.err_timeout, 1);
    end
    check("done_pulses", done_count - d0, has_one);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: still running at %0t, required finish before 200000", $time);
    $fatal(1);
  end

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.pix_valid    = 1'b0;
    bus.pix_data     = 8'd0;
    bus.cnt_valid_i  = 1'b0;
    bus.code_valid_i = 1'b0;

    frames[0] = '{px: mk(1, 2, 3, 4, 5, 6),   gap_after: -1, start_at: -1, exp_err: 1'b0};
    frames[1] = '{px: mk(0, 2, 9, 1, 5, 3),   gap_after: -1, start_at: -1, exp_err: 1'b1};
    frames[2] = '{px: mk(6, 6, 6, 6, 6, 6),   gap_after: -1, start_at: -1, exp_err: 1'b0};
    frames[3] = '{px: mk(1, 2, 3, 4, 5, 6),   gap_after: 3,  start_at: 1,  exp_err: 1'b1};
    frames[4] = '{px: mk(7, 1, 200, 4, 4, 2), gap_after: -1, start_at: -1, exp_err: 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_core_rst", bus.core_rst, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_pix_ready", bus.pix_ready, 0);
    check("rst_gray_valid", bus.gray_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_frame_cnt", bus.frame_cnt, 0);
    check("rst_errs", {bus.err_timeout, bus.err_range}, 0);
    reset = 1'b0;
    tick();
    check("idle_core_rst", bus.core_rst, 0);

    for (int i = 0; i < 5; i++) run_frame(frames[i]);

    // Extra start while waiting, then each event lands on its watchdog expiry cycle.
    begin_frame();
    feed(mk(1, 1, 1, 1, 1, 1), -1, -1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("late_start_busy", bus.busy, 1);
    check("late_start_core_rst", bus.core_rst, 0);
    repeat (TMO - 2) @(posedge clk);
    #1;
    bus.cnt_valid_i = 1'b1;
    tick();
    bus.cnt_valid_i = 1'b0;
    check("race_cnt_timeout", bus.err_timeout, 0);
    check("race_cnt_busy", bus.busy, 1);
    check("race_cnt_core_rst", bus.core_rst, 0);
    repeat (TMO - 1) @(posedge clk);
    #1;
    bus.code_valid_i = 1'b1;
    tick();
    bus.code_valid_i = 1'b0;
    exp_fc++;
    check("race_code_done", bus.done, 1);
    check("race_code_timeout", bus.err_timeout, 0);
    check("race_code_frame_cnt", bus.frame_cnt, exp_fc);
    tick();

    // Asynchronous reset in the middle of FEED.
    begin_frame();
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'd2;
    exp_q.push_back(8'd2);
    tick();
    bus.pix_data = 8'd3;
    exp_q.push_back(8'd3);
    tick();
    bus.pix_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_core_rst", bus.core_rst, 1);
    check("async_busy", bus.busy, 0);
    check("async_pix_ready", bus.pix_ready, 0);
    check("async_gray_valid", bus.gray_valid, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("async_frame_cnt", bus.frame_cnt, 0);
    check("async_err_range", bus.err_range, 0);
    exp_fc = 8'd0;
    tick();
    run_frame(frames[0]);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
